// File: rtl/text_vram_arbiter_if.sv
// CPU text-port handshake and character-RAM port shared by the text VRAM arbiter.
// slave = arbiter side, master = CPU/RAM side.
interface text_vram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/text_vram_arbiter.sv
// Character-RAM arbiter: display fetch owns phase 0 of every cell, CPU req/ack uses the rest.
// Optional macro TEXT_ARB_RDATA_REG_EN adds a HOLD state that registers CPU read data.
module text_vram_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          dot_counter,
  input  logic [8:0]          scanline_counter,
  text_vram_arbiter_if.slave  bus,
  output logic [7:0]          char_code,
  output logic                char_valid
);

  localparam logic [ADDR_W:0]   CELLS_W = (ADDR_W+1)'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] COLS_W  = ADDR_W'(COLS);

  // ISSUE is never registered: it is the IDLE cycle in which a request is accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rd_ok_q, rd_ok_d;
  logic              fetch_q, fetch_d;
  logic              char_valid_q, char_valid_d;
  logic [7:0]        char_code_q, char_code_d;
  logic [2:0]        phase;
  logic              disp_slot;
  logic              cpu_issue;
  logic              in_range;
  logic [ADDR_W-1:0] disp_addr;
  logic              unused_scan_lsb;

  assign phase           = dot_counter[2:0];
  assign unused_scan_lsb = ^scanline_counter[3:0];
  assign in_range        = {1'b0, bus.cpu_addr} < CELLS_W;
  assign disp_addr       = ADDR_W'(scanline_counter[8:4]) * COLS_W + ADDR_W'(dot_counter[9:3]);

  // Qualifying with rst_n keeps the combinational RAM strobes quiet while reset is held.
  assign disp_slot = rst_n && (phase == 3'd0);
  assign cpu_issue = rst_n && (state_q == IDLE) && bus.cpu_req && (phase != 3'd0);

`ifdef TEXT_ARB_RDATA_REG_EN
  logic [7:0] rdata_q, rdata_d;
  localparam state_e AFTER_ISSUE = HOLD;
`else
  localparam state_e AFTER_ISSUE = RESP;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    rd_ok_d       = rd_ok_q;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 8'h00;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = 8'h00;
`ifdef TEXT_ARB_RDATA_REG_EN
    rdata_d       = rdata_q;
`endif

    if (disp_slot) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = disp_addr;
    end

    case (state_q)
      IDLE: begin
        if (cpu_issue) begin
          bus.ram_en    = in_range;
          bus.ram_we    = in_range && bus.cpu_we;
          bus.ram_addr  = in_range ? bus.cpu_addr : '0;
          bus.ram_wdata = in_range ? bus.cpu_wdata : 8'h00;
          rd_ok_d       = in_range && !bus.cpu_we;
          state_d       = AFTER_ISSUE;
        end
      end
      HOLD: begin
`ifdef TEXT_ARB_RDATA_REG_EN
        rdata_d = rd_ok_q ? bus.ram_rdata : 8'h00;
`endif
        state_d = RESP;
      end
      RESP: begin
        bus.cpu_ack = 1'b1;
`ifdef TEXT_ARB_RDATA_REG_EN
        bus.cpu_rdata = rdata_q;
`else
        bus.cpu_rdata = rd_ok_q ? bus.ram_rdata : 8'h00;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display read lands one cycle after the phase-0 strobe and is published during phase 2.
  always_comb begin
    fetch_d      = disp_slot;
    char_valid_d = fetch_q;
    char_code_d  = fetch_q ? bus.ram_rdata : char_code_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_ok_q      <= 1'b0;
      fetch_q      <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      rd_ok_q      <= rd_ok_d;
      fetch_q      <= fetch_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
    end
  end

`ifdef TEXT_ARB_RDATA_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= 8'h00;
    else        rdata_q <= rdata_d;
  end
`endif

  assign char_code  = char_code_q;
  assign char_valid = char_valid_q;

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Scoreboard bench for text_vram_arbiter: random CPU traffic against a free-running display
// schedule, checked against a golden memory image and cycle-level latency expectations.
module tb_text_vram_arbiter;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int FRAME = 640 * 480;
`ifdef TEXT_ARB_RDATA_REG_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 1;
`endif

  typedef struct {
    bit         we;
    bit         in_range;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          issue_cyc;
    int          ack_cyc;
  } txn_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] dot_counter;
  logic [8:0] scanline_counter;
  logic [7:0] char_code;
  logic       char_valid;

  text_vram_arbiter_if #(.ADDR_W(12)) bus ();

  text_vram_arbiter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dot_counter      (dot_counter),
    .scanline_counter (scanline_counter),
    .bus              (bus),
    .char_code        (char_code),
    .char_valid       (char_valid)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pos = 0;
  int          reset_pos = 0;
  logic [7:0]  gold [4096];
  logic [7:0]  mem  [4096];
  txn_t        cq[$];
  logic [7:0]  dq[$];

  function automatic logic [7:0] init_byte(input int i);
    if (i == 81) return 8'h41;
    if (i == 5)  return 8'h7E;
    return 8'((i * 29 + 7) ^ (i >> 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame position generator: held at reset_pos while reset is asserted.
  initial begin
    dot_counter      = 10'd0;
    scanline_counter = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) pos = reset_pos;
      else        pos = (pos + 1) % FRAME;
      dot_counter      = 10'(pos % 640);
      scanline_counter = 9'(pos / 640);
    end
  end

  // Synchronous single-port character RAM.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_byte(i);
    bus.ram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.ram_en === 1'b1) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
      end
    end
  end

  // Monitor: RAM-port ownership, display character stream and CPU acks.
  initial begin
    int   ph;
    int   exp_a;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs",
              32'({bus.cpu_ack, bus.cpu_rdata, bus.ram_en, bus.ram_we, bus.ram_addr,
                   bus.ram_wdata, char_code, char_valid}), 32'd0);
        dq.delete();
      end else begin
        ph = int'(dot_counter) % 8;
        if (ph == 0) begin
          exp_a = (int'(scanline_counter) / 16) * COLS + int'(dot_counter) / 8;
          check("disp_strobe", 32'({bus.ram_en, bus.ram_we}), 32'b10);
          check("disp_addr", 32'(bus.ram_addr), 32'(exp_a));
          dq.push_back(gold[exp_a]);
        end else if (cq.size() > 0 && cq[0].issue_cyc == cyc) begin
          if (cq[0].in_range) begin
            check("cpu_issue", 32'({bus.ram_en, bus.ram_we, bus.ram_addr}),
                  32'({1'b1, cq[0].we, cq[0].addr}));
            if (cq[0].we) check("cpu_wdata", 32'(bus.ram_wdata), 32'(cq[0].wdata));
          end else begin
            check("oor_no_ram", 32'(bus.ram_en), 32'd0);
          end
        end else begin
          check("ram_idle", 32'(bus.ram_en), 32'd0);
        end

        if (ph == 2) begin
          check("char_valid_ph2", 32'(char_valid), 32'(dq.size() > 0));
          if (char_valid && dq.size() > 0) check("char_code", 32'(char_code), 32'(dq.pop_front()));
        end else begin
          check("char_valid_off", 32'(char_valid), 32'd0);
        end

        if (bus.cpu_ack) begin
          check("ack_pending", 32'(cq.size() > 0), 32'd1);
          if (cq.size() > 0) begin
            t = cq.pop_front();
            check("ack_cycle", 32'(cyc), 32'(t.ack_cyc));
            if (!t.we) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(t.rdata));
          end
        end
      end
    end
  end

  // One CPU transaction, request raised in the first cycle whose phase equals ph.
  task automatic cpu_txn(input bit we, input logic [11:0] addr, input logic [7:0] wd, input int ph);
    txn_t t;
    int   n;
    @(posedge clk); #2;
    while (int'(dot_counter) % 8 != ph) begin @(posedge clk); #2; end
    t.we        = we;
    t.addr      = addr;
    t.wdata     = wd;
    t.in_range  = int'(addr) < CELLS;
    t.issue_cyc = (ph == 0) ? cyc + 1 : cyc;
    t.ack_cyc   = t.issue_cyc + ACK_LAT;
    t.rdata     = (!we && t.in_range) ? gold[addr] : 8'h00;
    cq.push_back(t);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    if (ph == 0) @(posedge clk);
    @(posedge clk); #1;
    if (we && t.in_range) gold[addr] = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cpu_ack && n < 8);
    check("ack_seen", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
  endtask

  task automatic random_traffic(input int count);
    logic [11:0] a;
    for (int k = 0; k < count; k++) begin
      a = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(CELLS, 4095))
                                      : 12'($urandom_range(0, CELLS - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      cpu_txn(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 7));
    end
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 4096; i++) gold[i] = init_byte(i);
    rst_n         = 1'b0;
    reset_pos     = 16 * 640;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'd3;
    bus.cpu_wdata = 8'hFF;

    repeat (4) @(posedge clk);
    #2;
    bus.cpu_req = 1'b0;
    rst_n       = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("first_valid_dot2", 32'({char_valid, char_code}), 32'({1'b1, init_byte(80)}));
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("fetch_addr_81", 32'({bus.ram_en, bus.ram_addr}), 32'({1'b1, 12'd81}));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fetch_char_41", 32'({char_valid, char_code}), 32'({1'b1, 8'h41}));

    cpu_txn(1'b1, 12'd3,    8'h5A, 0);
    cpu_txn(1'b0, 12'd5,    8'h00, 3);
    cpu_txn(1'b0, 12'd3,    8'h00, 6);
    cpu_txn(1'b1, 12'd2400, 8'hAA, 5);
    cpu_txn(1'b0, 12'd4095, 8'h00, 6);
    cpu_txn(1'b0, 12'd2399, 8'h00, 7);

    random_traffic(220);

    // Abort a read in its ISSUE cycle; restart near the end of the frame.
    @(posedge clk); #2;
    while (int'(dot_counter) % 8 != 3) begin @(posedge clk); #2; end
    reset_pos    = 479 * 640 + 600;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'd5;
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.cpu_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_ack_after_abort", 32'(bus.cpu_ack), 32'd0);
    cpu_txn(1'b0, 12'd5, 8'h00, 4);

    random_traffic(150);

    repeat (20) @(posedge clk);
    check("all_acked", 32'(cq.size()), 32'd0);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== gold[i]) diffs++;
    check("ram_image", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
